calc2_port_responder: RTL and testbench

- Single-port responder for the calc2 request/response interface: the device end that a calc2 initiator (bench or RTL master) drives.
- Captures two-cycle requests (cmd/op1/tag, then op2) and evaluates add/sub/shift-left/shift-right.
- Returns resp/data/tag after a fixed, parameterised latency.
- Uses: reference model and stub for initiator-side blocks, and building block for a multi-port calc2 model.

---
 rtl/calc2_port_responder.sv | 157 +++++++++++++++
 tb/tb_calc2_port_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/calc2_port_responder.sv
// calc2 device-side responder: captures two-cycle requests, evaluates
// add/sub/shl/shr and returns the result after a fixed pipeline latency.
module calc2_port_responder #(
    parameter int unsigned LATENCY   = 3,
    parameter bit          TAG_CHECK = 1'b1
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    input  logic [1:0]  req_tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OP2  = 1'b1
    } state_t;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    state_t state_q, state_d;
    logic   capture, push;

    logic [3:0]  cap_cmd;
    logic [31:0] cap_op1;
    logic [1:0]  cap_tag;

    logic [3:0]  pending;
    logic [3:0]  clr_mask, set_mask;
    logic        tag_err;

    logic [32:0] sum;
    logic [1:0]  res_resp, fin_resp;
    logic [31:0] res_data, fin_data;

    logic [LATENCY-1:0] st_valid;
    // st_own marks responses whose request set a pending bit; only those may clear it
    logic [LATENCY-1:0] st_own;
    logic [1:0]         st_resp [LATENCY];
    logic [31:0]        st_data [LATENCY];
    logic [1:0]         st_tag  [LATENCY];

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_cmd_in != 4'd0) begin
                    capture = 1'b1;
                    state_d = OP2;
                end
            end
            OP2: begin
                push    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sum      = {1'b0, cap_op1} + {1'b0, req_data_in};
        res_resp = RESP_ERR;
        res_data = 32'd0;
        case (cap_cmd)
            4'd1: begin
                if (!sum[32]) begin
                    res_resp = RESP_OK;
                    res_data = sum[31:0];
                end
            end
            4'd2: begin
                if (req_data_in <= cap_op1) begin
                    res_resp = RESP_OK;
                    res_data = cap_op1 - req_data_in;
                end
            end
            4'd5: begin
                res_resp = RESP_OK;
                res_data = cap_op1 << req_data_in[4:0];
            end
            4'd6: begin
                res_resp = RESP_OK;
                res_data = cap_op1 >> req_data_in[4:0];
            end
            default: begin
                res_resp = RESP_ERR;
                res_data = 32'd0;
            end
        endcase
    end

    // A tag being presented on this same edge is already free for reuse.
    always_comb begin
        clr_mask = (st_valid[LATENCY-1] && st_own[LATENCY-1]) ?
                   (4'b0001 << st_tag[LATENCY-1]) : 4'b0000;
        tag_err  = TAG_CHECK && pending[cap_tag] && !clr_mask[cap_tag];
        set_mask = (push && !tag_err) ? (4'b0001 << cap_tag) : 4'b0000;
        fin_resp = tag_err ? RESP_ERR : res_resp;
        fin_data = tag_err ? 32'd0 : res_data;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cap_cmd  <= 4'd0;
            cap_op1  <= 32'd0;
            cap_tag  <= 2'd0;
            pending  <= 4'd0;
            st_valid <= '0;
            st_own   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_resp[i] <= RESP_NONE;
                st_data[i] <= 32'd0;
                st_tag[i]  <= 2'd0;
            end
            out_resp <= RESP_NONE;
            out_data <= 32'd0;
            out_tag  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cap_cmd <= req_cmd_in;
                cap_op1 <= req_data_in;
                cap_tag <= req_tag_in;
            end
            pending <= (pending & ~clr_mask) | set_mask;

            for (int i = LATENCY - 1; i > 0; i--) begin
                st_valid[i] <= st_valid[i-1];
                st_own[i]   <= st_own[i-1];
                st_resp[i]  <= st_resp[i-1];
                st_data[i]  <= st_data[i-1];
                st_tag[i]   <= st_tag[i-1];
            end
            st_valid[0] <= push;
            st_own[0]   <= push && !tag_err;
            st_resp[0]  <= push ? fin_resp : RESP_NONE;
            st_data[0]  <= push ? fin_data : 32'd0;
            st_tag[0]   <= push ? cap_tag : 2'd0;

            out_resp <= st_valid[LATENCY-1] ? st_resp[LATENCY-1] : RESP_NONE;
            out_data <= (st_valid[LATENCY-1] && st_resp[LATENCY-1] == RESP_OK) ?
                        st_data[LATENCY-1] : 32'd0;
            out_tag  <= st_valid[LATENCY-1] ? st_tag[LATENCY-1] : 2'd0;
        end
    end

    assign busy = |st_valid;

endmodule

// File: tb/tb_calc2_port_responder.sv
// Self-checking bench for calc2_port_responder: directed and random requests
// compared every cycle against a per-cycle expectation table.
module tb_calc2_port_responder;

    localparam int LAT  = 3;
    localparam int MAXC = 4096;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_cmd_in = 4'd0;
    logic [31:0] req_data_in = 32'd0;
    logic [1:0]  req_tag_in = 2'd0;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        busy;

    calc2_port_responder #(.LATENCY(LAT), .TAG_CHECK(1'b1)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    always #5 c_clk = ~c_clk;

    int edge_cnt = 0;
    always @(posedge c_clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    // Expected outputs seen after edge n, and number of responses in flight after edge n.
    logic [1:0]  e_resp [MAXC];
    logic [31:0] e_data [MAXC];
    logic [1:0]  e_tag  [MAXC];
    int          bcnt   [MAXC];
    // Edge at which each tag's owning response is presented (tag free from then on).
    int          rel    [4];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, obs, exp, edge_cnt);
        end
    endtask

    task automatic clear_model(input int from);
        for (int i = from; i < MAXC; i++) begin
            e_resp[i] = 2'd0;
            e_data[i] = 32'd0;
            e_tag[i]  = 2'd0;
            bcnt[i]   = 0;
        end
        for (int t = 0; t < 4; t++) rel[t] = 0;
    endtask

    // Reference: result from plain arithmetic; op2 captured at edge e2.
    task automatic model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] tg, input int e2);
        longint unsigned wide;
        logic [1:0]  r;
        logic [31:0] d;
        r = 2'd2;
        d = 32'd0;
        case (cmd)
            4'd1: begin
                wide = longint'(a) + longint'(b);
                if (wide <= 64'hFFFF_FFFF) begin r = 2'd1; d = a + b; end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << b[4:0]; end
            4'd6: begin r = 2'd1; d = a >> b[4:0]; end
            default: ;
        endcase
        if (rel[tg] > e2) begin
            r = 2'd2;
            d = 32'd0;
        end else begin
            rel[tg] = e2 + LAT;
        end
        e_resp[e2 + LAT] = r;
        e_data[e2 + LAT] = d;
        e_tag[e2 + LAT]  = tg;
        for (int i = e2; i < e2 + LAT; i++) bcnt[i]++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge c_clk);
            req_cmd_in  = 4'd0;
            req_data_in = $urandom;
            req_tag_in  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tg, input bit hold);
        @(negedge c_clk);
        req_cmd_in  = cmd;
        req_data_in = a;
        req_tag_in  = tg;
        model(cmd, a, b, tg, edge_cnt + 2);
        @(negedge c_clk);
        req_data_in = b;
        req_cmd_in  = hold ? cmd : 4'd0;
        req_tag_in  = 2'($urandom_range(0, 3));
    endtask

    bit mon_en = 1'b0;
    always @(negedge c_clk) begin
        if (mon_en) begin
            chk("resp", 32'(out_resp), 32'(e_resp[edge_cnt]));
            chk("data", out_data, e_data[edge_cnt]);
            chk("tag",  32'(out_tag),  32'(e_tag[edge_cnt]));
            chk("busy", 32'(busy), 32'(bcnt[edge_cnt] != 0));
        end
    end

    logic [3:0]  rc;
    logic [31:0] ra, rb;

    initial begin
        clear_model(0);
        #1;
        chk("rst_resp", 32'(out_resp), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_tag",  32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
        mon_en = 1'b1;
        idle(2);

        send(4'd1, 32'h30, 32'h20, 2'd1, 1'b0);
        idle(6);
        send(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 1'b1);
        send(4'd2, 32'h10, 32'h20, 2'd0, 1'b0);
        send(4'd2, 32'h20, 32'h20, 2'd3, 1'b0);
        idle(LAT + 2);
        send(4'd5, 32'h1, 32'h21, 2'd0, 1'b0);
        send(4'd6, 32'h8000_0000, 32'd31, 2'd1, 1'b0);
        send(4'd3, 32'h1234, 32'h5678, 2'd2, 1'b0);
        idle(LAT + 3);

        for (int t = 0; t < 4; t++) send(4'd1, 32'(t * 16), 32'd1, 2'(t), 1'b0);
        idle(LAT + 3);

        send(4'd1, 32'h7, 32'h8, 2'd1, 1'b0);
        send(4'd1, 32'h9, 32'hA, 2'd1, 1'b0);
        idle(2);
        send(4'd2, 32'h100, 32'h1, 2'd1, 1'b0);
        idle(LAT + 3);

        // Async reset while a response is in flight and a second request sits in OP2.
        send(4'd1, 32'h5, 32'h6, 2'd0, 1'b0);
        @(negedge c_clk);
        req_cmd_in  = 4'd2;
        req_data_in = 32'h9;
        req_tag_in  = 2'd3;
        @(posedge c_clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'(bcnt[edge_cnt] != 0));
        #1;
        reset = 1'b1;
        clear_model(edge_cnt);
        #1;
        chk("arst_resp", 32'(out_resp), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_tag",  32'(out_tag), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge c_clk);
        req_cmd_in = 4'd0;
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
        send(4'd1, 32'h30, 32'h20, 2'd0, 1'b0);
        idle(LAT + 6);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    rc = 4'd1;
                2, 3:    rc = 4'd2;
                4, 5:    rc = 4'd5;
                6, 7:    rc = 4'd6;
                default: begin
                    rc = 4'($urandom_range(3, 15));
                    if (rc == 4'd5 || rc == 4'd6) rc = 4'd4;
                end
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            send(rc, ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        idle(LAT + 4);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
